// File: rtl/logo_cmd_sequencer_if.sv
// Bundle between the PS2 front end, the command sequencer and the processor.
//   key_valid/key_code     : raw scancode strobe from the PS2 interface
//   cmd_valid/cmd_ready    : command hand-over handshake, cmd_word packed ASCII
//   char_count             : characters currently buffered
//   echo_valid/ascii_echo  : one-cycle echo pulse for the LCD
//   overflow               : sticky "character dropped" flag
// The slave modport is the sequencer; the master modport is its environment.
interface logo_cmd_sequencer_if #(
    parameter int unsigned MAX_CHARS = 4
) ();
    localparam int unsigned CountW = $clog2(MAX_CHARS + 1);

    logic                   key_valid;
    logic [7:0]             key_code;
    logic                   cmd_ready;
    logic                   cmd_valid;
    logic [8*MAX_CHARS-1:0] cmd_word;
    logic [CountW-1:0]      char_count;
    logic                   echo_valid;
    logic [7:0]             ascii_echo;
    logic                   overflow;

    modport master (
        output key_valid, key_code, cmd_ready,
        input  cmd_valid, cmd_word, char_count, echo_valid, ascii_echo, overflow
    );

    modport slave (
        input  key_valid, key_code, cmd_ready,
        output cmd_valid, cmd_word, char_count, echo_valid, ascii_echo, overflow
    );
endinterface

// File: rtl/logo_cmd_sequencer.sv
// Turns raw PS2 scancode bytes into packed LOGO command words.
// Ports:
//   clock  : system clock, all state on posedge
//   reset  : synchronous, active-high
//   bus    : logo_cmd_sequencer_if.slave (key input, command handshake, echo, status)
// Break (F0) and extended (E0) prefixed bytes are discarded; make codes are mapped to
// ASCII, edit keys modify the buffer, and Enter hands the buffer over on valid/ready.
module logo_cmd_sequencer #(
    parameter int unsigned MAX_CHARS = 4,
    parameter logic [7:0]  KEY_ENTER = 8'h5A,
    parameter logic [7:0]  KEY_BKSP  = 8'h66,
    parameter logic [7:0]  KEY_ESC   = 8'h76,
    parameter logic [7:0]  KEY_SPACE = 8'h29
) (
    input logic                 clock,
    input logic                 reset,
    logo_cmd_sequencer_if.slave bus
);
    localparam int unsigned WordW  = 8 * MAX_CHARS;
    localparam int unsigned CountW = $clog2(MAX_CHARS + 1);
    localparam logic [CountW-1:0] MaxCount = CountW'(MAX_CHARS);
    localparam logic [7:0] CodeBreak = 8'hF0;
    localparam logic [7:0] CodeExt   = 8'hE0;

    typedef enum logic [1:0] {StNormal, StBreak, StExt, StExtBreak} prefix_e;
    typedef enum logic {StCollect, StSubmit} cmd_e;

    prefix_e           prefix_q;
    cmd_e              state_q;
    logic [WordW-1:0]  word_q;
    logic [CountW-1:0] count_q;
    logic              cmd_valid_q;
    logic              echo_valid_q;
    logic [7:0]        ascii_echo_q;
    logic              overflow_q;

    // Scancode set 2 to ASCII for letters and digits; 0 means unmapped.
    function automatic logic [7:0] map_ascii(input logic [7:0] code);
        case (code)
            8'h1C: return 8'h41;  8'h32: return 8'h42;  8'h21: return 8'h43;
            8'h23: return 8'h44;  8'h24: return 8'h45;  8'h2B: return 8'h46;
            8'h34: return 8'h47;  8'h33: return 8'h48;  8'h43: return 8'h49;
            8'h3B: return 8'h4A;  8'h42: return 8'h4B;  8'h4B: return 8'h4C;
            8'h3A: return 8'h4D;  8'h31: return 8'h4E;  8'h44: return 8'h4F;
            8'h4D: return 8'h50;  8'h15: return 8'h51;  8'h2D: return 8'h52;
            8'h1B: return 8'h53;  8'h2C: return 8'h54;  8'h3C: return 8'h55;
            8'h2A: return 8'h56;  8'h1D: return 8'h57;  8'h22: return 8'h58;
            8'h35: return 8'h59;  8'h1A: return 8'h5A;
            8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
            8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
            8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
            8'h46: return 8'h39;
            default: return 8'h00;
        endcase
    endfunction

    logic [7:0] mapped;
    logic [7:0] print_char;
    logic       is_print;
    logic       is_make;

    always_comb begin
        mapped     = map_ascii(bus.key_code);
        is_print   = (mapped != 8'h00) || (bus.key_code == KEY_SPACE);
        print_char = (bus.key_code == KEY_SPACE) ? 8'h20 : mapped;
        // Only a byte seen with no pending prefix is a make code.
        is_make    = bus.key_valid && (prefix_q == StNormal) &&
                     (bus.key_code != CodeBreak) && (bus.key_code != CodeExt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prefix_q     <= StNormal;
            state_q      <= StCollect;
            word_q       <= '0;
            count_q      <= '0;
            cmd_valid_q  <= 1'b0;
            echo_valid_q <= 1'b0;
            ascii_echo_q <= 8'h00;
            overflow_q   <= 1'b0;
        end else begin
            echo_valid_q <= 1'b0;

            // Prefix tracking runs in both command states so key releases stay in sync.
            if (bus.key_valid) begin
                case (prefix_q)
                    StNormal: begin
                        if (bus.key_code == CodeBreak) prefix_q <= StBreak;
                        else if (bus.key_code == CodeExt) prefix_q <= StExt;
                    end
                    StBreak:    prefix_q <= StNormal;
                    StExt:      prefix_q <= (bus.key_code == CodeBreak) ? StExtBreak : StNormal;
                    StExtBreak: prefix_q <= StNormal;
                endcase
            end

            if (state_q == StSubmit) begin
                // Make codes are dropped here, including one in the handshake cycle.
                if (bus.cmd_ready) begin
                    state_q     <= StCollect;
                    cmd_valid_q <= 1'b0;
                    word_q      <= '0;
                    count_q     <= '0;
                    overflow_q  <= 1'b0;
                end
            end else if (is_make) begin
                if (bus.key_code == KEY_ENTER) begin
                    if (count_q != '0) begin
                        state_q      <= StSubmit;
                        cmd_valid_q  <= 1'b1;
                        echo_valid_q <= 1'b1;
                        ascii_echo_q <= 8'h0D;
                    end
                end else if (bus.key_code == KEY_BKSP) begin
                    if (count_q != '0) begin
                        word_q       <= {8'h00, word_q[WordW-1:8]};
                        count_q      <= count_q - 1'b1;
                        echo_valid_q <= 1'b1;
                        ascii_echo_q <= 8'h08;
                    end
                end else if (bus.key_code == KEY_ESC) begin
                    word_q     <= '0;
                    count_q    <= '0;
                    overflow_q <= 1'b0;
                end else if (is_print) begin
                    if (count_q < MaxCount) begin
                        word_q       <= {word_q[WordW-9:0], print_char};
                        count_q      <= count_q + 1'b1;
                        echo_valid_q <= 1'b1;
                        ascii_echo_q <= print_char;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_word   = word_q;
    assign bus.char_count = count_q;
    assign bus.echo_valid = echo_valid_q;
    assign bus.ascii_echo = ascii_echo_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_logo_cmd_sequencer.sv
module tb_logo_cmd_sequencer;
    logic clock = 1'b0;
    logic reset;

    logo_cmd_sequencer_if #(.MAX_CHARS(4)) bus ();

    logo_cmd_sequencer #(.MAX_CHARS(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Every echo pulse seen, in order.
    logic [7:0] echo_q[$];
    always @(negedge clock) if (bus.echo_valid) echo_q.push_back(bus.ascii_echo);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        bus.cmd_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        echo_q.delete();
    endtask

    task automatic send(input logic [7:0] code);
        @(negedge clock);
        bus.key_code  = code;
        bus.key_valid = 1'b1;
        @(negedge clock);
        bus.key_valid = 1'b0;
    endtask

    function automatic logic [31:0] echo_packed();
        logic [31:0] w = 32'h0;
        foreach (echo_q[i]) w = (w << 8) | 32'(echo_q[i]);
        return w;
    endfunction

    // ---------------- reference model ----------------
    string      letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
    logic [7:0] codes[36] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
                              8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                              8'h46};

    function automatic logic [7:0] ref_ascii(input logic [7:0] code);
        if (code == 8'h29) return 8'h20;
        for (int i = 0; i < 36; i++) if (codes[i] == code) return letters[i];
        return 8'h00;
    endfunction

    logic [7:0] m_chars[$];
    bit         m_sub, m_ovf, m_echo_v, m_brk, m_ext;
    logic [7:0] m_echo;

    task automatic model_reset();
        m_chars.delete();
        m_sub = 0; m_ovf = 0; m_echo_v = 0; m_brk = 0; m_ext = 0; m_echo = 8'h00;
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w = 32'h0;
        foreach (m_chars[i]) w = (w << 8) | 32'(m_chars[i]);
        return w;
    endfunction

    task automatic model_step(input bit kv, input logic [7:0] code, input bit rdy);
        bit was_sub = m_sub;
        bit make = 0;
        logic [7:0] a;
        if (kv) begin
            // F0 drops the byte after it; E0 drops the next byte, or if that is F0 the one after.
            if (m_brk) m_brk = 0;
            else if (m_ext) begin m_ext = 0; if (code == 8'hF0) m_brk = 1; end
            else if (code == 8'hF0) m_brk = 1;
            else if (code == 8'hE0) m_ext = 1;
            else make = 1;
        end
        m_echo_v = 0;
        if (was_sub && rdy) begin m_chars.delete(); m_sub = 0; m_ovf = 0; end
        if (make && !was_sub) begin
            a = ref_ascii(code);
            if (code == 8'h5A) begin
                if (m_chars.size() > 0) begin m_sub = 1; m_echo_v = 1; m_echo = 8'h0D; end
            end else if (code == 8'h66) begin
                if (m_chars.size() > 0) begin
                    void'(m_chars.pop_back()); m_echo_v = 1; m_echo = 8'h08;
                end
            end else if (code == 8'h76) begin
                m_chars.delete(); m_ovf = 0;
            end else if (a != 8'h00) begin
                if (m_chars.size() < 4) begin m_chars.push_back(a); m_echo_v = 1; m_echo = a; end
                else m_ovf = 1;
            end
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic [63:0] keys;   // first key in [63:56]
        logic [3:0]  nkeys;
        logic [31:0] word;
        logic [2:0]  count;
        logic        ovf;
        logic        valid;
        logic [31:0] echo;
        logic [2:0]  necho;
    } vec_t;

    vec_t vecs[8];
    logic [7:0] pool[20] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h2D, 8'h44, 8'h16,
                             8'h45, 8'h29, 8'h66, 8'h66, 8'h76, 8'h5A, 8'h5A, 8'hF0, 8'hE0,
                             8'h07, 8'h75};

    initial begin
        reset = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        bus.cmd_ready = 1'b0;

        vecs[0] = '{64'h2DF02D44F0440000, 4'd6, 32'h0000524F, 3'd2, 1'b0, 1'b0, 32'h524F, 3'd2};
        vecs[1] = '{64'h1C32212324000000, 4'd5, 32'h41424344, 3'd4, 1'b1, 1'b0, 32'h41424344, 3'd4};
        vecs[2] = '{64'h2B23660000000000, 4'd3, 32'h00000046, 3'd1, 1'b0, 1'b0, 32'h464408, 3'd3};
        vecs[3] = '{64'h2B23666666000000, 4'd5, 32'h00000000, 3'd0, 1'b0, 1'b0, 32'h46440808, 3'd4};
        vecs[4] = '{64'hE075E0F075160000, 4'd6, 32'h00000031, 3'd1, 1'b0, 1'b0, 32'h31, 3'd1};
        vecs[5] = '{64'h1C32212324760000, 4'd6, 32'h00000000, 3'd0, 1'b0, 1'b0, 32'h41424344, 3'd4};
        vecs[6] = '{64'h2916000000000000, 4'd2, 32'h00002031, 3'd2, 1'b0, 1'b0, 32'h2031, 3'd2};
        vecs[7] = '{64'h2B5A000000000000, 4'd2, 32'h00000046, 3'd1, 1'b0, 1'b1, 32'h460D, 3'd2};

        do_reset();
        check("reset cmd_valid", 32'(bus.cmd_valid), 32'h0);
        check("reset word", bus.cmd_word, 32'h0);
        check("reset count", 32'(bus.char_count), 32'h0);
        check("reset echo", {bus.echo_valid, bus.ascii_echo}, 32'h0);
        check("reset overflow", 32'(bus.overflow), 32'h0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            for (int k = 0; k < int'(vecs[v].nkeys); k++) send(vecs[v].keys[63-8*k -: 8]);
            idle(1);
            check($sformatf("vec%0d word", v), bus.cmd_word, vecs[v].word);
            check($sformatf("vec%0d count", v), 32'(bus.char_count), 32'(vecs[v].count));
            check($sformatf("vec%0d overflow", v), 32'(bus.overflow), 32'(vecs[v].ovf));
            check($sformatf("vec%0d cmd_valid", v), 32'(bus.cmd_valid), 32'(vecs[v].valid));
            check($sformatf("vec%0d echo count", v), echo_q.size(), 32'(vecs[v].necho));
            check($sformatf("vec%0d echo bytes", v), echo_packed(), vecs[v].echo);
        end

        // Submit held while not ready; bytes arriving meanwhile are dropped.
        do_reset();
        send(8'h2B); send(8'h23); send(8'h5A);
        idle(1);
        check("t4 cmd_valid", 32'(bus.cmd_valid), 32'h1);
        check("t4 word", bus.cmd_word, 32'h00004644);
        echo_q.delete();
        send(8'h1C); send(8'hF0); send(8'h5A);
        idle(5);
        check("t4 held valid", 32'(bus.cmd_valid), 32'h1);
        check("t4 held word", bus.cmd_word, 32'h00004644);
        check("t4 held count", 32'(bus.char_count), 32'h2);
        check("t4 no echo in submit", echo_q.size(), 32'h0);
        // Handshake with a make code in the same cycle.
        @(negedge clock);
        bus.cmd_ready = 1'b1;
        bus.key_code  = 8'h1C;
        bus.key_valid = 1'b1;
        @(negedge clock);
        bus.cmd_ready = 1'b0;
        bus.key_valid = 1'b0;
        #1;
        check("t4 valid after hs", 32'(bus.cmd_valid), 32'h0);
        check("t4 count after hs", 32'(bus.char_count), 32'h0);
        idle(2);
        check("t4 1C dropped word", bus.cmd_word, 32'h0);
        check("t4 1C dropped echo", echo_q.size(), 32'h0);

        // Reset in SUBMIT, then Enter on an empty buffer.
        do_reset();
        send(8'h2B); send(8'h5A);
        idle(1);
        check("t6 in submit", 32'(bus.cmd_valid), 32'h1);
        do_reset();
        check("t6 reset valid", 32'(bus.cmd_valid), 32'h0);
        check("t6 reset word", bus.cmd_word, 32'h0);
        check("t6 reset count", 32'(bus.char_count), 32'h0);
        check("t6 reset echo", {bus.echo_valid, bus.ascii_echo}, 32'h0);
        send(8'h5A);
        idle(2);
        check("t6 empty enter valid", 32'(bus.cmd_valid), 32'h0);
        check("t6 empty enter echo", echo_q.size(), 32'h0);

        // Random traffic against the reference model, checked every cycle.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            bit kv, rdy;
            logic [7:0] code;
            @(negedge clock);
            check("rnd cmd_valid", 32'(bus.cmd_valid), 32'(m_sub));
            check("rnd word", bus.cmd_word, model_word());
            check("rnd count", 32'(bus.char_count), m_chars.size());
            check("rnd overflow", 32'(bus.overflow), 32'(m_ovf));
            check("rnd echo_valid", 32'(bus.echo_valid), 32'(m_echo_v));
            check("rnd ascii_echo", 32'(bus.ascii_echo), 32'(m_echo));
            kv   = ($urandom_range(0, 1) == 1);
            rdy  = ($urandom_range(0, 3) == 0);
            code = pool[$urandom_range(0, 19)];
            bus.key_valid = kv;
            bus.key_code  = code;
            bus.cmd_ready = rdy;
            model_step(kv, code, rdy);
        end
        @(negedge clock);
        bus.key_valid = 1'b0;
        bus.cmd_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
